tlp_c2f_fetch: RTL and testbench
================================

Name: tlp_c2f_fetch

Overview:
FPGA-initiated read engine for CPU->FPGA bulk transfer. Builds Memory Read request TLPs toward host memory and consumes the matching CplD completions. It emits the returned payload as a 64-bit qword stream for downstream buffering. It shares the 64-bit Avalon-ST TLP format of the hard IP and sits alongside the endpoint TLP transceiver on an arbitrated tx port and a routed rx completion port.

Parameters:
CHUNK_QWORDS, 16, qwords per MRd request (128 bytes; Length field = 2*CHUNK_QWORDS DW); power of two, 8..64
TIMEOUT_CYCLES, 125000, cycles without completion data before the outstanding request is declared failed (1ms at 125MHz)
SPACE_BITS, 10, width of downstream free-space count

Ports:
pcieClk_in  in  1  125MHz core clock; the only clock
reset_in  in  1  synchronous, active-high reset
cfgBusDev_in  in  16  requester ID (BusID) assigned on enumeration
dmaBase_in  in  64  host byte address of first chunk; low log2(CHUNK_QWORDS*8) bits ignored
dmaCount_in  in  16  number of chunks to fetch
dmaStart_in  in  1  single-cycle start pulse
dmaBusy_out  out  1  transfer in progress
dmaDone_out  out  1  single-cycle pulse on successful completion
dmaError_out  out  1  sticky error flag; cleared by next accepted start
txData_out  out  64  request TLP qword
txValid_out  out  1  tx valid
txReady_in  in  1  tx ready
txSOP_out  out  1  first qword of TLP
txEOP_out  out  1  last qword of TLP
rxData_in  in  64  completion TLP qword
rxValid_in  in  1  rx valid
rxReady_out  out  1  rx ready
rxSOP_in  in  1  first qword of TLP
rxEOP_in  in  1  last qword of TLP
c2fData_out  out  64  payload qword
c2fValid_out  out  1  payload valid; no backpressure
c2fSpace_in  in  SPACE_BITS  free qword slots downstream

Behaviour:
- Reset: all outputs 0; rxReady_out is 0 during reset and 1 from the next cycle onward (completions are always drained). Tag counter = 0; FSM = IDLE. Reset mid-transfer aborts silently, with no done and no error. Any later completions are discarded.
- FSM: IDLE -> (start) WAIT_SPACE -> HDR0 -> HDR1 -> WAIT_CPL -> WAIT_SPACE (chunks remain) | DONE -> IDLE.
- IDLE transitions:
  - start with count=0: dmaDone_out pulses next cycle; no TLP is issued.
  - start while busy: ignored.
- WAIT_SPACE: advance only when c2fSpace_in >= CHUNK_QWORDS. Otherwise hold with txValid_out=0.
- Request format:
  - HDR0: {DW1,DW0}, SOP=1. DW0 = fmt (000 for 3DW, 001 for 4DW), type 00000, TC/attr 0, Length = 2*CHUNK_QWORDS. DW1 = {cfgBusDev_in, tag[7:0], lastBE=F, firstBE=F}.
  - HDR1, EOP=1: 3DW form is {32'h0, addr[31:2],2'b00}. 4DW form (addr[63:32]!=0) is {addr lo, addr hi}.
  - Data and flags stay stable while txValid_out=1 and txReady_in=0.
  - Latency: start at cycle N, HDR0 valid at N+1 when space permits.
- Tags: 5-bit, increment modulo 32 per request; exactly one request outstanding.
- Completion parse:
  - Beat0: DW0 type must be CplD/Cpl; DW1 status[15:13]; byte count[11:0].
  - Beat1: DW2 requester ID, tag[15:8], lower address[6:0]; upper DW is pad.
  - Beats 2..EOP carry data.
- Completion acceptance rules:
  - Packets with a tag mismatch or a requester ID mismatch are dropped whole, with no effect.
  - A matching packet whose status != 000, or whose lower address bit 2 = 1, sets error. The engine then returns to IDLE, drops busy and does not pulse done.
  - A matching completion may be split at 64-byte RCB boundaries. Data qwords are counted, and the chunk ends when the count reaches CHUNK_QWORDS.
- Output timing: each accepted data beat drives c2fValid_out exactly 1 cycle later (registered).
- Chunk advance: address += CHUNK_QWORDS*8, remaining -= 1. The last chunk goes to DONE, which pulses dmaDone_out and drops busy in the same cycle.
- Timeout: the counter resets on HDR1 acceptance and on each matching data beat. Reaching TIMEOUT_CYCLES sets error and returns to IDLE.
- Address wrap past 2^64: unspecified, software must not request it.

Decomposition:
- Add to tlp_xcvr_pkg: Tag (5-bit) typedef, TLP fmt/type constants (MRD3, MRD4, CPL, CPLD), CplStatus enum, FetchState enum, ChunkCount typedef.
- One sub-module, tlp_cpl_recv: the rx completion parser. Outputs a data strobe, match/error/end-of-packet flags and the qword.
- The top level holds the request FSM, address/tag/count registers and the timeout counter.

Test Plan:
1. 3DW request and single completion:
   - Stimulus: cfgBusDev=0x0100, base 0x1000_0000, count 1, space 16.
   - Required tx: HDR0=0x010000FF_00000020, HDR1 low DW=0x10000000.
   - Feed one CplD (32 DW, tag 0) with data 0..15: 16 c2f beats 0..15, each 1 cycle after its rx beat, then done pulse.
2. 4DW request: base 0x1_0000_0000 -> DW0=0x20000020; HDR1=0x00000000_00000001.
3. Split completion:
   - Stimulus: count 2; each chunk returned as two 16-DW CplDs (byte count 128 then 64).
   - Required: 32 c2f beats; second request uses tag 1 at address +0x80; done once.
4. Error status: completion status UR (001) -> dmaError_out=1, busy=0, no further TLP; next start clears error.
5. Backpressure:
   - space=15 -> no txValid_out; raise space to 16 -> HDR0 issued.
   - txReady_in low 3 cycles -> HDR0 held unchanged.
6. Timeout:
   - Stimulus: TIMEOUT_CYCLES=100; inject a completion with foreign tag 7 plus a request-ID-mismatched completion.
   - Required: both discarded; error asserted exactly 100 cycles after HDR1 accepted.

Source files
------------

// File: rtl/tlp_c2f_fetch_pkg.sv
// tlp_c2f_fetch_pkg: shared types, TLP codes and header builder for the CPU->FPGA fetch engine
package tlp_c2f_fetch_pkg;
    typedef logic [4:0] tag_t;
    typedef logic [15:0] chunk_count_t;
    localparam logic [7:0] MRD3 = 8'h00;
    localparam logic [7:0] MRD4 = 8'h20;
    localparam logic [7:0] CPL = 8'h0A;
    localparam logic [7:0] CPLD = 8'h4A;
    typedef enum logic [2:0] {
        CPL_SC = 3'b000,
        CPL_UR = 3'b001,
        CPL_CRS = 3'b010,
        CPL_CA = 3'b100
    } cpl_status_e;
    typedef enum logic [2:0] {IDLE, WAIT_SPACE, HDR0, HDR1, WAIT_CPL, DONE} fetch_state_e;
    function automatic logic [63:0] mrd_hdr0(input logic [15:0] req_id, input tag_t tag,
                                             input logic four_dw, input logic [9:0] len);
        return {req_id, 3'b000, tag, 8'hFF, four_dw ? MRD4 : MRD3, 14'h0, len};
    endfunction
endpackage

// File: rtl/tlp_c2f_fetch_cpl_recv.sv
// tlp_cpl_recv: parses rx completions, flags a header match/error and strobes matching payload qwords
module tlp_cpl_recv
    import tlp_c2f_fetch_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req_id,
    input  tag_t        tag,
    input  logic [63:0] data,
    input  logic        valid,
    input  logic        sop,
    input  logic        eop,
    output logic        ready,
    output logic        strobe,
    output logic        error,
    output logic [63:0] qword
);
    logic in_hdr, is_cpl, bad_status, keep, beat, hdr1, match;
    // decode the current beat against the header state captured from beat 0
    always_comb begin
        beat = valid && ready;
        hdr1 = beat && in_hdr && !sop;
        match = hdr1 && is_cpl && data[31:16] == req_id && data[15:8] == {3'b000, tag};
        error = match && (bad_status || data[2]);
        strobe = beat && keep && !sop;
        qword = data;
    end
    // track packet position; keep is set only for a clean matching completion's data beats
    always_ff @(posedge clk) begin
        if (rst) begin
            ready <= 1'b0;
            in_hdr <= 1'b0;
            is_cpl <= 1'b0;
            bad_status <= 1'b0;
            keep <= 1'b0;
        end else begin
            ready <= 1'b1;
            if (beat && sop) begin
                in_hdr <= !eop;
                is_cpl <= data[31:24] == CPL || data[31:24] == CPLD;
                bad_status <= data[47:45] != CPL_SC;
                keep <= 1'b0;
            end else if (hdr1) begin
                in_hdr <= 1'b0;
                keep <= match && !error && !eop;
            end else if (beat && eop) begin
                keep <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/tlp_c2f_fetch.sv
// tlp_c2f_fetch: issues chunked MRd requests to host memory and streams the returned payload
module tlp_c2f_fetch
    import tlp_c2f_fetch_pkg::*;
#(
    parameter int CHUNK_QWORDS = 16,
    parameter int TIMEOUT_CYCLES = 125000,
    parameter int SPACE_BITS = 10
) (
    input  logic                  pcieClk_in,
    input  logic                  reset_in,
    input  logic [15:0]           cfgBusDev_in,
    input  logic [63:0]           dmaBase_in,
    input  logic [15:0]           dmaCount_in,
    input  logic                  dmaStart_in,
    output logic                  dmaBusy_out,
    output logic                  dmaDone_out,
    output logic                  dmaError_out,
    output logic [63:0]           txData_out,
    output logic                  txValid_out,
    input  logic                  txReady_in,
    output logic                  txSOP_out,
    output logic                  txEOP_out,
    input  logic [63:0]           rxData_in,
    input  logic                  rxValid_in,
    output logic                  rxReady_out,
    input  logic                  rxSOP_in,
    input  logic                  rxEOP_in,
    output logic [63:0]           c2fData_out,
    output logic                  c2fValid_out,
    input  logic [SPACE_BITS-1:0] c2fSpace_in
);
    localparam logic [63:0] CHUNK_BYTES = 64'(CHUNK_QWORDS * 8);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    fetch_state_e state;
    logic [63:0] addr, base, req_addr, hdr0, hdr1, cpl_qword;
    tag_t tag;
    chunk_count_t remaining;
    logic [6:0] qcnt;
    logic [TW-1:0] timer;
    logic cpl_strobe, cpl_error, space_ok, start_ok, launch;

    tlp_cpl_recv u_recv (
        .clk(pcieClk_in),
        .rst(reset_in),
        .req_id(cfgBusDev_in),
        .tag(tag),
        .data(rxData_in),
        .valid(rxValid_in),
        .sop(rxSOP_in),
        .eop(rxEOP_in),
        .ready(rxReady_out),
        .strobe(cpl_strobe),
        .error(cpl_error),
        .qword(cpl_qword)
    );

    // launch decision and request header words; a fresh start uses the incoming base directly
    always_comb begin
        base = dmaBase_in & ~(CHUNK_BYTES - 64'd1);
        space_ok = c2fSpace_in >= SPACE_BITS'(CHUNK_QWORDS);
        start_ok = dmaStart_in && (state == IDLE || state == DONE);
        launch = space_ok && (state == WAIT_SPACE || (start_ok && dmaCount_in != '0));
        req_addr = state == WAIT_SPACE ? addr : base;
        hdr0 = mrd_hdr0(cfgBusDev_in, tag, |req_addr[63:32], 10'(2 * CHUNK_QWORDS));
        hdr1 = |addr[63:32] ? {addr[31:0], addr[63:32]} : {32'h0, addr[31:2], 2'b00};
    end

    // request FSM with registered tx, status and payload outputs
    always_ff @(posedge pcieClk_in) begin
        if (reset_in) begin
            state <= IDLE;
            addr <= '0;
            tag <= '0;
            remaining <= '0;
            qcnt <= '0;
            timer <= '0;
            dmaBusy_out <= 1'b0;
            dmaDone_out <= 1'b0;
            dmaError_out <= 1'b0;
            txData_out <= '0;
            txValid_out <= 1'b0;
            txSOP_out <= 1'b0;
            txEOP_out <= 1'b0;
            c2fData_out <= '0;
            c2fValid_out <= 1'b0;
        end else begin
            dmaDone_out <= 1'b0;
            c2fValid_out <= cpl_strobe && state == WAIT_CPL;
            c2fData_out <= cpl_qword;
            case (state)
                IDLE, DONE: begin
                    state <= IDLE;
                    if (dmaStart_in) begin
                        dmaError_out <= 1'b0;
                        addr <= base;
                        remaining <= dmaCount_in;
                        if (dmaCount_in == '0) begin
                            state <= DONE;
                            dmaDone_out <= 1'b1;
                        end else begin
                            state <= WAIT_SPACE;
                            dmaBusy_out <= 1'b1;
                        end
                    end
                end
                HDR0: if (txReady_in) begin
                    state <= HDR1;
                    txSOP_out <= 1'b0;
                    txEOP_out <= 1'b1;
                    txData_out <= hdr1;
                end
                HDR1: if (txReady_in) begin
                    state <= WAIT_CPL;
                    txValid_out <= 1'b0;
                    txEOP_out <= 1'b0;
                    timer <= '0;
                    qcnt <= '0;
                end
                WAIT_CPL: begin
                    timer <= timer + 1'b1;
                    if (cpl_error || timer == TW'(TIMEOUT_CYCLES - 1)) begin
                        state <= IDLE;
                        dmaBusy_out <= 1'b0;
                        dmaError_out <= 1'b1;
                        tag <= tag + 1'b1;
                    end else if (cpl_strobe) begin
                        timer <= '0;
                        qcnt <= qcnt + 1'b1;
                        if (qcnt == 7'(CHUNK_QWORDS - 1)) begin
                            tag <= tag + 1'b1;
                            addr <= addr + CHUNK_BYTES;
                            remaining <= remaining - 1'b1;
                            state <= remaining == 16'd1 ? DONE : WAIT_SPACE;
                            dmaBusy_out <= remaining != 16'd1;
                            dmaDone_out <= remaining == 16'd1;
                        end
                    end
                end
                default: ;
            endcase
            if (launch) begin
                state <= HDR0;
                txValid_out <= 1'b1;
                txSOP_out <= 1'b1;
                txEOP_out <= 1'b0;
                txData_out <= hdr0;
            end
        end
    end
endmodule

// File: tb/tb_tlp_c2f_fetch.sv
// tb_tlp_c2f_fetch: directed stimulus with scoreboard queues checked by a negedge monitor
module tb_tlp_c2f_fetch;
    logic clk = 0, rst = 1;
    logic [15:0] cfg = 16'h0100;
    logic [63:0] base = '0;
    logic [15:0] count = '0;
    logic start = 0;
    logic busy, done, err, tx_valid, tx_sop, tx_eop, rx_ready, c2f_valid;
    logic [63:0] tx_data, c2f_data;
    logic tx_ready = 1;
    logic [63:0] rx_data = '0;
    logic rx_valid = 0, rx_sop = 0, rx_eop = 0, rx_is_data = 0;
    logic [9:0] space = 10'd16;

    int passed = 0, total = 0;
    int cyc = 0, tx_beats = 0, exp_done = 0, hdr1_acc = 0, err_cyc = 0;
    logic c2f_due = 0, err_prev = 0;
    logic [65:0] exp_tx[$];
    logic [63:0] exp_c2f[$];

    tlp_c2f_fetch #(.CHUNK_QWORDS(16), .TIMEOUT_CYCLES(100), .SPACE_BITS(10)) dut (
        .pcieClk_in(clk), .reset_in(rst), .cfgBusDev_in(cfg), .dmaBase_in(base),
        .dmaCount_in(count), .dmaStart_in(start), .dmaBusy_out(busy), .dmaDone_out(done),
        .dmaError_out(err), .txData_out(tx_data), .txValid_out(tx_valid), .txReady_in(tx_ready),
        .txSOP_out(tx_sop), .txEOP_out(tx_eop), .rxData_in(rx_data), .rxValid_in(rx_valid),
        .rxReady_out(rx_ready), .rxSOP_in(rx_sop), .rxEOP_in(rx_eop), .c2fData_out(c2f_data),
        .c2fValid_out(c2f_valid), .c2fSpace_in(space)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic logic [63:0] h0(input logic [4:0] t, input logic [63:0] a);
        return {16'h0100, 3'b000, t, 8'hFF, (a[63:32] != 0) ? 8'h20 : 8'h00, 24'h000020};
    endfunction

    function automatic logic [63:0] h1(input logic [63:0] a);
        return (a[63:32] != 0) ? {a[31:0], a[63:32]} : {32'h0, a[31:0]};
    endfunction

    task automatic push_req(input logic [63:0] hd0, input logic [63:0] hd1);
        exp_tx.push_back({2'b10, hd0});
        exp_tx.push_back({2'b01, hd1});
    endtask

    // monitor: pops scoreboard entries whenever the DUT presents tx, payload or done
    always @(negedge clk) begin
        if (tx_valid && tx_ready) begin
            tx_beats++;
            if (tx_eop) hdr1_acc = cyc + 1;
            if (exp_tx.size() == 0) chk("tx_extra", tx_valid, 0);
            else chk("tx_beat", {tx_sop, tx_eop, tx_data}, exp_tx.pop_front());
        end
        if (c2f_valid || c2f_due) begin
            chk("c2f_timing", c2f_valid, c2f_due);
            if (c2f_valid) begin
                if (exp_c2f.size() == 0) chk("c2f_extra", c2f_valid, 0);
                else chk("c2f_data", c2f_data, exp_c2f.pop_front());
            end
        end
        c2f_due = rx_valid && rx_ready && rx_is_data;
        if (done) begin
            chk("done_expected", exp_done > 0, 1);
            if (exp_done > 0) exp_done--;
        end
        if (err && !err_prev) err_cyc = cyc;
        err_prev = err;
    end

    task automatic do_start(input logic [63:0] b, input logic [15:0] c);
        @(posedge clk); #1 base = b; count = c; start = 1;
        @(posedge clk); #1 start = 0;
    endtask

    task automatic wait_tx(input int target);
        int n = 0;
        while (tx_beats < target && n < 300) begin @(posedge clk); #1 n++; end
        chk("tx_wait", tx_beats >= target, 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (exp_done != 0 && n < 300) begin @(posedge clk); #1 n++; end
        chk("done_wait", exp_done, 0);
    endtask

    task automatic send_cpl(input logic [15:0] rid, input logic [4:0] t, input logic [2:0] st,
                            input logic [11:0] bc, input logic [6:0] la, input int nd,
                            input logic [63:0] d0, input logic good);
        logic [31:0] dw0;
        dw0 = (nd > 0) ? (32'h4A000000 | 32'(2 * nd)) : 32'h0A000000;
        @(posedge clk); #1 rx_valid = 1; rx_sop = 1; rx_eop = 0; rx_is_data = 0;
        rx_data = {16'h0, st, 1'b0, bc, dw0};
        @(posedge clk); #1 rx_sop = 0; rx_eop = (nd == 0);
        rx_data = {32'h0, rid, 3'b000, t, 1'b0, la};
        for (int i = 0; i < nd; i++) begin
            @(posedge clk); #1 rx_data = d0 + 64'(i); rx_eop = (i == nd - 1); rx_is_data = good;
            if (good) exp_c2f.push_back(d0 + 64'(i));
        end
        @(posedge clk); #1 rx_valid = 0; rx_eop = 0; rx_is_data = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        repeat (3) @(posedge clk);
        #1 chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_error", err, 0);
        chk("reset_txvalid", tx_valid, 0);
        chk("reset_c2fvalid", c2f_valid, 0);
        chk("reset_rxready", rx_ready, 0);
        rst = 0;
        @(posedge clk); #1 chk("rxready_after_reset", rx_ready, 1);

        // 3DW request, single completion, start-while-busy ignored
        push_req(64'h010000FF_00000020, 64'h00000000_10000000);
        exp_done++;
        t0 = tx_beats;
        do_start(64'h0000_0000_1000_0000, 16'd1);
        chk("hdr0_latency", tx_valid, 1);
        chk("busy_set", busy, 1);
        wait_tx(t0 + 2);
        do_start(64'h0000_0000_9000_0000, 16'd5);
        chk("busy_while_ignored_start", busy, 1);
        send_cpl(16'h0100, 5'd0, 3'b000, 12'd128, 7'h00, 16, 64'd0, 1);
        wait_done();
        chk("busy_cleared", busy, 0);

        // 4DW request
        push_req(64'h010001FF_20000020, 64'h00000000_00000001);
        exp_done++;
        t0 = tx_beats;
        do_start(64'h0000_0001_0000_0000, 16'd1);
        wait_tx(t0 + 2);
        send_cpl(16'h0100, 5'd1, 3'b000, 12'd128, 7'h00, 16, 64'h100, 1);
        wait_done();

        // two chunks, each split at the 64-byte boundary
        push_req(h0(5'd2, 64'h2000_0000), h1(64'h2000_0000));
        push_req(h0(5'd3, 64'h2000_0080), h1(64'h2000_0080));
        exp_done++;
        t0 = tx_beats;
        do_start(64'h0000_0000_2000_0000, 16'd2);
        wait_tx(t0 + 2);
        send_cpl(16'h0100, 5'd2, 3'b000, 12'd128, 7'h00, 8, 64'h200, 1);
        send_cpl(16'h0100, 5'd2, 3'b000, 12'd64, 7'h40, 8, 64'h208, 1);
        wait_tx(t0 + 4);
        send_cpl(16'h0100, 5'd3, 3'b000, 12'd128, 7'h00, 8, 64'h300, 1);
        send_cpl(16'h0100, 5'd3, 3'b000, 12'd64, 7'h40, 8, 64'h308, 1);
        wait_done();

        // unsupported-request status
        push_req(h0(5'd4, 64'h3000_0000), h1(64'h3000_0000));
        t0 = tx_beats;
        do_start(64'h0000_0000_3000_0000, 16'd2);
        wait_tx(t0 + 2);
        send_cpl(16'h0100, 5'd4, 3'b001, 12'd0, 7'h00, 0, 64'd0, 0);
        repeat (20) @(posedge clk);
        #1 chk("ur_error", err, 1);
        chk("ur_busy", busy, 0);

        // downstream space and tx backpressure
        space = 10'd15;
        push_req(h0(5'd5, 64'h4000_0000), h1(64'h4000_0000));
        exp_done++;
        t0 = tx_beats;
        do_start(64'h0000_0000_4000_0000, 16'd1);
        chk("start_clears_error", err, 0);
        chk("no_space_txvalid", tx_valid, 0);
        repeat (5) @(posedge clk);
        #1 chk("no_space_hold", tx_valid, 0);
        tx_ready = 0; space = 10'd16;
        @(posedge clk); #1 chk("space_txvalid", tx_valid, 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1 chk("hdr0_held", {tx_valid, tx_sop, tx_data}, {2'b11, h0(5'd5, 64'h4000_0000)});
        end
        tx_ready = 1;
        wait_tx(t0 + 2);
        send_cpl(16'h0100, 5'd5, 3'b000, 12'd128, 7'h00, 16, 64'h500, 1);
        wait_done();

        // foreign completions ignored, then timeout
        push_req(h0(5'd6, 64'h5000_0000), h1(64'h5000_0000));
        t0 = tx_beats;
        do_start(64'h0000_0000_5000_0000, 16'd1);
        wait_tx(t0 + 2);
        send_cpl(16'h0100, 5'd7, 3'b000, 12'd32, 7'h00, 4, 64'h700, 0);
        send_cpl(16'h0200, 5'd6, 3'b000, 12'd32, 7'h00, 4, 64'h800, 0);
        begin
            int n = 0;
            while (!err && n < 300) begin @(posedge clk); #1 n++; end
        end
        @(negedge clk); #1 chk("timeout_cycles", err_cyc - hdr1_acc, 100);
        chk("timeout_busy", busy, 0);

        // zero-length start
        exp_done++;
        do_start(64'h0000_0000_6000_0000, 16'd0);
        chk("zero_done", done, 1);
        chk("zero_busy", busy, 0);
        chk("zero_clears_error", err, 0);
        @(posedge clk);

        // reset mid-transfer, stale completion, then tag restarts at 0
        push_req(h0(5'd7, 64'h7000_0000), h1(64'h7000_0000));
        t0 = tx_beats;
        do_start(64'h0000_0000_7000_0000, 16'd1);
        wait_tx(t0 + 2);
        @(posedge clk); #1 rst = 1;
        @(posedge clk); #1 chk("midreset_rxready", rx_ready, 0);
        chk("midreset_busy", busy, 0);
        rst = 0;
        send_cpl(16'h0100, 5'd7, 3'b000, 12'd128, 7'h00, 16, 64'h900, 0);
        repeat (5) @(posedge clk);
        #1 chk("stale_no_error", err, 0);
        push_req(h0(5'd0, 64'h6000_0000), h1(64'h6000_0000));
        exp_done++;
        t0 = tx_beats;
        do_start(64'h0000_0000_6000_0000, 16'd1);
        wait_tx(t0 + 2);
        send_cpl(16'h0100, 5'd0, 3'b000, 12'd128, 7'h00, 16, 64'hA00, 1);
        wait_done();

        repeat (5) @(posedge clk);
        #1 chk("tx_queue_empty", exp_tx.size(), 0);
        chk("c2f_queue_empty", exp_c2f.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
